// File: rtl/rr_sel_arbiter4_if.sv
// Request/select/capture bundle between the 4-channel arbiter,
// its mux and the downstream valid/ready consumer.
interface rr_sel_arbiter4_if #(
  parameter int n = 4
);
  logic [3:0]   req;
  logic [3:0]   lock;
  logic [n-1:0] mux_f;
  logic [1:0]   sel;
  logic [3:0]   ack;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_data;
  logic [1:0]   out_ch;

  modport master (
    output req, lock, mux_f, out_ready,
    input  sel, ack, out_valid, out_data, out_ch
  );

  modport slave (
    input  req, lock, mux_f, out_ready,
    output sel, ack, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/rr_sel_arbiter4.sv
// Round-robin 4-channel arbiter driving a 4:1 mux select, with burst
// lock and a zero-bubble registered valid/ready capture stage.
module rr_sel_arbiter4 #(
  parameter int n = 4
) (
  input logic             clk,
  input logic             rst,
  rr_sel_arbiter4_if.slave bus
);
  typedef enum logic {ARB, LOCKED} state_t;

  state_t       state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   last_sel_q, last_sel_d;
  logic [1:0]   out_ch_q, out_ch_d;
  logic         out_valid_q, out_valid_d;
  logic [n-1:0] out_data_q, out_data_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       win_vld;
  logic       can_load;
  logic       cap;

  // Reverse scan so the channel closest to ptr is assigned last and wins.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    if (state_q == LOCKED) begin
      win     = owner_q;
      win_vld = bus.req[owner_q];
    end else begin
      for (int i = 3; i >= 0; i--) begin
        idx = ptr_q + 2'(i);
        if (bus.req[idx]) begin
          win     = idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  assign can_load = !out_valid_q || bus.out_ready;
  assign cap      = win_vld && can_load;

  assign bus.sel       = win_vld ? win : last_sel_q;
  assign bus.ack       = cap ? (4'b0001 << win) : 4'b0000;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    last_sel_d  = last_sel_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (cap) begin
      out_data_d  = bus.mux_f;
      out_ch_d    = win;
      out_valid_d = 1'b1;
      last_sel_d  = win;
      unique case (state_q)
        ARB: begin
          if (bus.lock[win]) begin
            state_d = LOCKED;
            owner_d = win;
          end else begin
            ptr_d = win + 2'd1;
          end
        end
        LOCKED: begin
          if (!bus.lock[owner_q]) begin
            state_d = ARB;
            ptr_d   = owner_q + 2'd1;
          end
        end
        default: state_d = ARB;
      endcase
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      last_sel_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      last_sel_q  <= last_sel_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// Directed-vector bench for rr_sel_arbiter4 with a behavioural 4:1 mux
// whose input k carries base+k.
module tb_rr_sel_arbiter4;
  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] base;
  int           vec_cnt;
  int           err_cnt;

  rr_sel_arbiter4_if #(.n(N)) bus ();

  rr_sel_arbiter4 #(.n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mux_f = base + N'(bus.sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One capture of channel ch: combinational checks, then post-edge checks.
  task automatic cap(input string tag, input logic [3:0] r,
                     input logic [3:0] l, input logic [1:0] ch);
    bus.req       = r;
    bus.lock      = l;
    bus.out_ready = 1'b1;
    #1;
    check_vec({tag, ".sel"}, 32'(bus.sel), 32'(ch));
    check_vec({tag, ".ack"}, 32'(bus.ack), 32'(4'b0001 << ch));
    tick();
    check_vec({tag, ".ch"}, 32'(bus.out_ch), 32'(ch));
    check_vec({tag, ".data"}, 32'(bus.out_data), 32'(base + N'(ch)));
    check_vec({tag, ".vld"}, 32'(bus.out_valid), 32'd1);
  endtask

  initial begin
    vec_cnt       = 0;
    err_cnt       = 0;
    base          = 8'h50;
    rst           = 1'b1;
    bus.req       = '0;
    bus.lock      = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_vec("rst.vld", 32'(bus.out_valid), 32'd0);
    check_vec("rst.data", 32'(bus.out_data), 32'd0);
    check_vec("rst.ch", 32'(bus.out_ch), 32'd0);
    check_vec("rst.sel", 32'(bus.sel), 32'd0);
    check_vec("rst.ack", 32'(bus.ack), 32'd0);

    // Load a word, then reset mid-cycle: outputs clear without a clock edge.
    cap("pre", 4'b0001, 4'b0000, 2'd0);
    #2;
    rst = 1'b1;
    #1;
    check_vec("arst.vld", 32'(bus.out_valid), 32'd0);
    check_vec("arst.data", 32'(bus.out_data), 32'd0);
    check_vec("arst.ch", 32'(bus.out_ch), 32'd0);
    rst = 1'b0;

    base = 8'h60;
    for (int i = 0; i < 5; i++)
      cap($sformatf("all%0d", i), 4'b1111, 4'b0000, 2'(i));

    // ptr=1: ch2 -> ptr3; ch3 -> ptr0; ch0 -> ptr1; ch1 proves ptr=1.
    base = 8'h70;
    cap("wrap.c2", 4'b0100, 4'b0000, 2'd2);
    cap("wrap.c3", 4'b1001, 4'b0000, 2'd3);
    cap("wrap.c0", 4'b1001, 4'b0000, 2'd0);
    cap("wrap.c1", 4'b0011, 4'b0000, 2'd1);
    cap("solo.a", 4'b1000, 4'b0000, 2'd3);
    cap("solo.b", 4'b1000, 4'b0000, 2'd3);

    // Drain to empty, ptr=0.
    bus.req = '0;
    tick();
    check_vec("drain.vld", 32'(bus.out_valid), 32'd0);

    base          = 8'h80;
    bus.req       = 4'b0110;
    bus.out_ready = 1'b0;
    #1;
    check_vec("bp.ack0", 32'(bus.ack), 32'b0010);
    tick();
    check_vec("bp.ch0", 32'(bus.out_ch), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check_vec($sformatf("bp.ack%0d", i + 1), 32'(bus.ack), 32'd0);
      check_vec($sformatf("bp.sel%0d", i + 1), 32'(bus.sel), 32'd2);
      tick();
      check_vec($sformatf("bp.ch%0d", i + 1), 32'(bus.out_ch), 32'd1);
      check_vec($sformatf("bp.dat%0d", i + 1), 32'(bus.out_data), 32'h81);
      check_vec($sformatf("bp.vld%0d", i + 1), 32'(bus.out_valid), 32'd1);
    end
    cap("bp.rel", 4'b0110, 4'b0000, 2'd2);

    // ptr=3; ch0 locks for four words, lock[1] is ignored as non-owner.
    base = 8'h90;
    cap("lk.a", 4'b0011, 4'b0011, 2'd0);
    cap("lk.b", 4'b0011, 4'b0011, 2'd0);
    cap("lk.c", 4'b0011, 4'b0011, 2'd0);
    cap("lk.d", 4'b0011, 4'b0010, 2'd0);
    cap("lk.e", 4'b0011, 4'b0000, 2'd1);
    cap("lk.f", 4'b1111, 4'b0000, 2'd2);

    // Idle after the ch2 grant: sel holds, one drain empties the stage.
    bus.req = '0;
    #1;
    check_vec("idle.sel", 32'(bus.sel), 32'd2);
    check_vec("idle.ack", 32'(bus.ack), 32'd0);
    tick();
    check_vec("idle.vld", 32'(bus.out_valid), 32'd0);
    check_vec("idle.sel2", 32'(bus.sel), 32'd2);

    // ptr=3: ch3 locks, then drops req; others must wait.
    base = 8'hA0;
    cap("rb.lk", 4'b1000, 4'b1000, 2'd3);
    bus.req  = 4'b0111;
    bus.lock = 4'b0000;
    #1;
    check_vec("rb.wait.ack", 32'(bus.ack), 32'd0);
    check_vec("rb.wait.sel", 32'(bus.sel), 32'd3);
    tick();
    check_vec("rb.wait.ack2", 32'(bus.ack), 32'd0);
    bus.req  = 4'b1000;
    bus.lock = 4'b1000;
    #1;
    rst = 1'b1;
    #1;
    check_vec("rb.rst.vld", 32'(bus.out_valid), 32'd0);
    rst = 1'b0;
    cap("rb.first", 4'b1111, 4'b0000, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end
endmodule

// File: doc/rr_sel_arbiter4.md
Name: rr_sel_arbiter4

Overview:
- Four-channel round-robin arbiter that sits directly upstream of the n-bit 4:1 multiplexer.
- Each cycle it picks one requesting channel and drives the mux select `sel`.
- It captures the mux output `mux_f` into a registered valid/ready output stage and returns a one-cycle acknowledge to the winning channel.
- A `lock` input lets the current winner keep ownership for multi-word bursts.

Parameters:
- n, 4, data width; must match the mux width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- req  input  4  per-channel request; req[k] means channel k has a word on mux input ik
- lock  input  4  per-channel burst lock; lock[k] is only honoured while channel k is the current owner
- mux_f  input  n  data returned from the mux output f
- sel  output  2  mux select; combinational
- ack  output  4  one-hot, one-cycle capture acknowledge; combinational
- out_valid  output  1  registered output holds a word
- out_ready  input  1  downstream accepts the word
- out_data  output  n  registered word
- out_ch  output  2  channel that produced out_data

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - out_valid=0, out_data=0, out_ch=0.
  - Priority pointer ptr=0; last_sel=0; state=ARB.
  - Reset mid-burst discards the lock and any pending word.
- can_load = !out_valid | out_ready.
- Winner selection in state ARB:
  - Scan channels ptr, ptr+1, ptr+2, ptr+3, all mod 4.
  - The winner is the first channel with req set.
- Winner selection in state LOCKED:
  - The winner is owner if req[owner]=1; no other channel may win.
- sel:
  - Equals the winner when a winner exists.
  - Otherwise equals last_sel, so it never glitches to an arbitrary value when idle.
- Capture condition: winner exists AND can_load. When it holds:
  - ack[winner]=1 for that cycle only.
  - At the clock edge: out_data<=mux_f, out_ch<=winner, out_valid<=1, last_sel<=winner.
- Drain: out_valid & out_ready with no capture in the same cycle → out_valid<=0 at the edge.
- Simultaneous drain and capture: the output stays valid and the new word replaces the old one. This gives zero bubble and 1 word/cycle throughput.
- Backpressure: out_valid=1 and out_ready=0 → no capture, ack=0, out_data and out_ch held stable, ptr and state frozen.
- Pointer update on capture in ARB:
  - lock[winner]=0 → ptr<=winner+1 mod 4 (3 wraps to 0).
  - lock[winner]=1 → state<=LOCKED, owner<=winner, ptr unchanged.
- In LOCKED:
  - Capture with lock[owner]=1 → stay LOCKED.
  - Capture with lock[owner]=0 (last burst word) → state<=ARB, ptr<=owner+1 mod 4.
  - req[owner]=0 while LOCKED → no capture; the state stays LOCKED and other requests wait (no timeout).
- lock[k] for a non-owner channel has no effect.
- Latency: mux_f to out_data is 1 clock; req to ack is 0 clocks (same cycle).
- Arithmetic: the pointer and all channel indices are 2-bit and wrap naturally; data width is exactly n with no extension.

Test Plan:
- Reset then all-req:
  - Stimulus: rst pulse mid-cycle, then req=4'b1111, lock=0, out_ready=1.
  - Required: outputs clear immediately on rst. Grants then go 0,1,2,3,0; ack=0001,0010,0100,1000,0001. out_data tracks the mux word 1 cycle later; out_valid stays 1.
- Pointer wrap:
  - Stimulus: req=4'b1001, grant ch3 (ptr=3).
  - Required: next grant is ch0 and ptr becomes 1. req=4'b1000 alone keeps being granted.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with req=4'b0110.
  - Required: exactly one capture (ch1), then ack=0 and out_data/out_ch stable for 3 cycles. On out_ready=1, the ch2 word is captured in the same cycle as the drain.
- Burst lock:
  - Stimulus: req=4'b0011; ch0 holds lock=1 for 3 captures, then lock=0.
  - Required: 4 consecutive ch0 grants, then ch1, and ptr ends at 2. lock[1] asserted while ch0 owns the grant is ignored.
- Idle sel hold:
  - Stimulus: req=0 after a ch2 grant.
  - Required: sel stays 2'b10, ack=0, and out_valid drops after one accepted drain.
- Reset mid-burst:
  - Stimulus: rst asserted while LOCKED on ch3.
  - Required: after release with req=4'b1111, the first grant is ch0.
